// File: rtl/dp_pkg.sv
// Shared definitions for the MIPS multi-cycle control sequencer: opcodes, functs,
// ALU encodings, fault codes, FSM states and the decoded control bundle.
package dp_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;
  localparam logic [2:0] AluNor = 3'b100;

  typedef enum logic [1:0] {
    FaultNone    = 2'b00,
    FaultIllegal = 2'b01,
    FaultImem    = 2'b10,
    FaultDmem    = 2'b11
  } fault_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StPause,
    StHalt
  } state_e;

  // mem_to_reg marks a load; the write-back itself is only enabled on dmem_ready.
  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_b;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [2:0] alu_ctrl;
    logic       mem_access;
    logic       mem_store;
  } ctrl_t;

endpackage

// File: rtl/dp_decode.sv
// Combinational instruction decoder: opcode/funct -> control bundle plus illegal flag.
// Illegal encodings produce an all-zero bundle.
module dp_decode
  import dp_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    unique case (i_op)
      OpRtype: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        unique case (i_funct)
          FnAdd:   o_ctrl.alu_ctrl = AluAdd;
          FnSub:   o_ctrl.alu_ctrl = AluSub;
          FnAnd:   o_ctrl.alu_ctrl = AluAnd;
          FnOr:    o_ctrl.alu_ctrl = AluOr;
          FnNor:   o_ctrl.alu_ctrl = AluNor;
          FnSlt:   o_ctrl.alu_ctrl = AluSlt;
          default: begin
            o_ctrl    = '0;
            o_illegal = 1'b1;
          end
        endcase
      end
      OpBeq: begin
        o_ctrl.branch   = 1'b1;
        o_ctrl.alu_ctrl = AluSub;
      end
      OpJ: begin
        o_ctrl.jump     = 1'b1;
        o_ctrl.alu_ctrl = AluAnd;
      end
      OpAddi: begin
        o_ctrl.alu_src_b = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_ctrl  = AluAdd;
      end
      OpLw, OpSw: begin
        o_ctrl.alu_src_b  = 1'b1;
        o_ctrl.alu_ctrl   = AluAdd;
        o_ctrl.mem_access = 1'b1;
        o_ctrl.mem_to_reg = (i_op == OpLw);
        o_ctrl.mem_store  = (i_op == OpSw);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for the single-cycle MIPS datapath: fetch over
// req/ready, decode, drive controls, stall on data memory and gate the PC with pc_we.
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrc_B,
  output logic             MemtoReg,
  output logic             Branch,
  output logic             Jump,
  output logic [2:0]       ALU_Control,
  output logic [25:0]      inst_field,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned     WaitW    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

  state_e           r_state, w_state_d, w_next;
  fault_e           r_fault, w_fault_d;
  logic [31:0]      r_ir;
  logic [WaitW-1:0] r_wait;
  logic [CNT_W-1:0] r_count;
  ctrl_t            w_ctrl;
  logic             w_illegal, w_wait_done, w_ir_load, w_commit;

  dp_decode u_decode (
    .i_op      (r_ir[31:26]),
    .i_funct   (r_ir[5:0]),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  assign w_wait_done = (r_wait == WaitLast);
  assign w_next      = step_mode ? StPause : (run ? StFetch : StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_fault <= FaultNone;
      r_ir    <= '0;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_fault <= w_fault_d;
      if (w_ir_load) r_ir <= imem_rdata;
      // Any state change restarts the wait count, covering entry to FETCH and MEM.
      if (w_state_d != r_state) r_wait <= '0;
      else if (r_state == StFetch || r_state == StMem) r_wait <= r_wait + 1'b1;
      if (w_commit && (r_count != '1)) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_fault_d = r_fault;
    w_ir_load = 1'b0;
    unique case (r_state)
      StIdle:  if (run) w_state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          w_ir_load = 1'b1;
          w_state_d = StExec;
        end else if (w_wait_done) begin
          w_state_d = StHalt;
          w_fault_d = FaultImem;
        end
      end
      StExec: begin
        if (w_illegal) begin
          w_state_d = StHalt;
          w_fault_d = FaultIllegal;
        end else if (w_ctrl.mem_access) begin
          w_state_d = StMem;
        end else begin
          w_state_d = w_next;
        end
      end
      StMem: begin
        if (dmem_ready) begin
          w_state_d = w_next;
        end else if (w_wait_done) begin
          w_state_d = StHalt;
          w_fault_d = FaultDmem;
        end
      end
      StPause: begin
        if (step) w_state_d = StFetch;
        else if (!run) w_state_d = StIdle;
      end
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    w_commit    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrc_B    = 1'b0;
    MemtoReg    = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    ALU_Control = 3'b000;
    unique case (r_state)
      StFetch: imem_req = 1'b1;
      StExec: begin
        RegWrite    = w_ctrl.reg_write;
        RegDst      = w_ctrl.reg_dst;
        ALUSrc_B    = w_ctrl.alu_src_b;
        Branch      = w_ctrl.branch;
        Jump        = w_ctrl.jump;
        ALU_Control = w_ctrl.alu_ctrl;
        w_commit    = !w_illegal && !w_ctrl.mem_access;
      end
      StMem: begin
        dmem_req    = 1'b1;
        dmem_we     = w_ctrl.mem_store;
        ALUSrc_B    = w_ctrl.alu_src_b;
        ALU_Control = w_ctrl.alu_ctrl;
        // Load write-back only on the completing cycle, when Data_in is valid.
        w_commit    = dmem_ready;
        MemtoReg    = dmem_ready && w_ctrl.mem_to_reg;
        RegWrite    = dmem_ready && w_ctrl.mem_to_reg;
      end
      default: ;
    endcase
  end

  assign pc_we       = w_commit;
  assign inst_field  = r_ir[25:0];
  assign halted      = (r_state == StHalt);
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule
